// File: rtl/qpu_ifu_flush_rspdr.sv
// qpu_ifu_flush_rspdr: responder end of the branch-mispredict flush handshake.
// Owns the fetch PC, issues sequential fetches, drains stale responses on a
// flush, redirects the PC to op1+op2 and acks the requester.
// Optional feature macro: QPU_IFU_FLUSH_CNT_EN adds the flush_cnt port/counter.
module qpu_ifu_flush_rspdr #(
  parameter int unsigned PC_SIZE  = 32,
  parameter int unsigned MAX_OUTS = 4,
  parameter int unsigned OUTS_W   = 3,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               brchmis_flush_req,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op1,
  input  logic [PC_SIZE-1:0] brchmis_flush_add_op2,
  output logic               brchmis_flush_ack,
  output logic               ifu_flush_pulse,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_SIZE-1:0] ifu_req_pc,
  input  logic               ifu_rsp_valid,
`ifdef QPU_IFU_FLUSH_CNT_EN
  output logic               ifu_rsp_kill,
  output logic [31:0]        flush_cnt
`else
  output logic               ifu_rsp_kill
`endif
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ACK} state_e;

  state_e              state_q, state_d;
  logic [PC_SIZE-1:0]  pc_q, pc_d;
  logic [PC_SIZE-1:0]  tgt_q, tgt_d;
  logic [OUTS_W-1:0]   outs_q, outs_d;
  logic                req_hs;
  logic                rsp_dec;
  logic                flush_accept;

  // Output decode, outstanding-count update and next-state selection
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tgt_d        = tgt_q;
    flush_accept = ~rst & (state_q == ST_RUN) & brchmis_flush_req;

    ifu_req_pc        = pc_q;
    ifu_req_valid     = ~rst & (state_q == ST_RUN) & ~brchmis_flush_req &
                        (outs_q < OUTS_W'(MAX_OUTS));
    ifu_flush_pulse   = flush_accept;
    brchmis_flush_ack = ~rst & (state_q == ST_ACK);
    // A response arriving in the accept cycle already belongs to the old path.
    ifu_rsp_kill      = ~rst & ifu_rsp_valid & ((state_q == ST_DRAIN) | flush_accept);

    req_hs  = ifu_req_valid & ifu_req_ready;
    // A response with nothing outstanding is a protocol error; the count holds at 0.
    rsp_dec = ifu_rsp_valid & (outs_q != '0);
    outs_d  = outs_q + OUTS_W'(req_hs) - OUTS_W'(rsp_dec);

    unique case (state_q)
      ST_RUN: begin
        if (req_hs) pc_d = pc_q + PC_SIZE'(4);
        if (flush_accept) begin
          tgt_d   = brchmis_flush_add_op1 + brchmis_flush_add_op2;
          state_d = (outs_d == '0) ? ST_ACK : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outs_d == '0) state_d = ST_ACK;
      end
      ST_ACK: begin
        pc_d    = tgt_q;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      outs_q  <= outs_d;
    end
  end

`ifdef QPU_IFU_FLUSH_CNT_EN
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating count of completed flushes
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if ((state_q == ST_ACK) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Flush counter register
  always_ff @(posedge clk) begin
    if (rst) flush_cnt_q <= '0;
    else     flush_cnt_q <= flush_cnt_d;
  end

  assign flush_cnt = flush_cnt_q;
`endif

  // Responses must never arrive with nothing outstanding
  a_rsp_with_outs: assert property (@(posedge clk) disable iff (rst)
    ifu_rsp_valid |-> (outs_q != '0));

endmodule

// File: tb/tb_qpu_ifu_flush_rspdr.sv
// Directed testbench for qpu_ifu_flush_rspdr (MAX_OUTS=3, RESET_PC=0).
module tb_qpu_ifu_flush_rspdr;

  logic        clk = 1'b0;
  logic        rst;
  logic        brchmis_flush_req;
  logic [31:0] brchmis_flush_add_op1;
  logic [31:0] brchmis_flush_add_op2;
  logic        brchmis_flush_ack;
  logic        ifu_flush_pulse;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_pc;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_kill;
`ifdef QPU_IFU_FLUSH_CNT_EN
  logic [31:0] flush_cnt;
`endif

  int checks = 0;
  int failures = 0;

  qpu_ifu_flush_rspdr #(
    .PC_SIZE (32),
    .MAX_OUTS(3),
    .OUTS_W  (3),
    .RESET_PC(32'h0)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .brchmis_flush_req    (brchmis_flush_req),
    .brchmis_flush_add_op1(brchmis_flush_add_op1),
    .brchmis_flush_add_op2(brchmis_flush_add_op2),
    .brchmis_flush_ack    (brchmis_flush_ack),
    .ifu_flush_pulse      (ifu_flush_pulse),
    .ifu_req_valid        (ifu_req_valid),
    .ifu_req_ready        (ifu_req_ready),
    .ifu_req_pc           (ifu_req_pc),
    .ifu_rsp_valid        (ifu_rsp_valid),
`ifdef QPU_IFU_FLUSH_CNT_EN
    .ifu_rsp_kill         (ifu_rsp_kill),
    .flush_cnt            (flush_cnt)
`else
    .ifu_rsp_kill         (ifu_rsp_kill)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic fr, input logic [31:0] a, input logic [31:0] b,
                       input logic rdy, input logic rsp);
    brchmis_flush_req     = fr;
    brchmis_flush_add_op1 = a;
    brchmis_flush_add_op2 = b;
    ifu_req_ready         = rdy;
    ifu_rsp_valid         = rsp;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    // Reset state
    chk("rst_valid", 32'(ifu_req_valid), 32'h0);
    chk("rst_pc", ifu_req_pc, 32'h0);
    chk("rst_ack", 32'(brchmis_flush_ack), 32'h0);
    chk("rst_pulse", 32'(ifu_flush_pulse), 32'h0);

    // Test 1: three sequential fetches, then full
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t1_v0", 32'(ifu_req_valid), 32'h1);
    chk("t1_pc0", ifu_req_pc, 32'h0);
    tick();
    chk("t1_pc1", ifu_req_pc, 32'h4);
    tick();
    chk("t1_pc2", ifu_req_pc, 32'h8);
    tick();
    chk("t1_full", 32'(ifu_req_valid), 32'h0);
    chk("t1_pc3", ifu_req_pc, 32'hC);

    // One response, no request: outs 3->2
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("t3_run_nokill", 32'(ifu_rsp_kill), 32'h0);
    tick();

    // Test 3: flush with outs=2, target 0x44
    drive(1'b1, 32'h40, 32'h4, 1'b1, 1'b0);
    chk("t3_pulse", 32'(ifu_flush_pulse), 32'h1);
    chk("t3_acc_valid", 32'(ifu_req_valid), 32'h0);
    tick();
    drive(1'b1, 32'h40, 32'h4, 1'b1, 1'b0);
    chk("t3_drain_ack", 32'(brchmis_flush_ack), 32'h0);
    chk("t3_drain_pulse", 32'(ifu_flush_pulse), 32'h0);
    drive(1'b1, 32'h40, 32'h4, 1'b1, 1'b1);
    chk("t3_kill1", 32'(ifu_rsp_kill), 32'h1);
    tick();
    drive(1'b1, 32'h40, 32'h4, 1'b1, 1'b1);
    chk("t3_kill2", 32'(ifu_rsp_kill), 32'h1);
    chk("t3_ack_early", 32'(brchmis_flush_ack), 32'h0);
    tick();
    drive(1'b1, 32'h40, 32'h4, 1'b1, 1'b0);
    chk("t3_ack", 32'(brchmis_flush_ack), 32'h1);
    chk("t3_ack_valid", 32'(ifu_req_valid), 32'h0);
    chk("t3_ack_nopulse", 32'(ifu_flush_pulse), 32'h0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t3_ack_once", 32'(brchmis_flush_ack), 32'h0);
    chk("t3_pc", ifu_req_pc, 32'h44);
    chk("t3_valid", 32'(ifu_req_valid), 32'h1);

    // Test 2: flush with outs=0 -> pulse@N, ack@N+1, pc@N+2
    drive(1'b1, 32'h100, 32'h20, 1'b0, 1'b0);
    chk("t2_pulse", 32'(ifu_flush_pulse), 32'h1);
    chk("t2_acc_ack", 32'(brchmis_flush_ack), 32'h0);
    tick();
    chk("t2_ack", 32'(brchmis_flush_ack), 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t2_pc", ifu_req_pc, 32'h120);
    chk("t2_valid", 32'(ifu_req_valid), 32'h1);
    tick();

    // Test 5: outs=1, flush coincides with the response
    drive(1'b1, 32'h200, 32'h0, 1'b1, 1'b1);
    chk("t5_pc", ifu_req_pc, 32'h124);
    chk("t5_noreq", 32'(ifu_req_valid), 32'h0);
    chk("t5_kill", 32'(ifu_rsp_kill), 32'h1);
    chk("t5_pulse", 32'(ifu_flush_pulse), 32'h1);
    tick();
    drive(1'b1, 32'h200, 32'h0, 1'b1, 1'b0);
    chk("t5_ack", 32'(brchmis_flush_ack), 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t5_redirect", ifu_req_pc, 32'h200);

    // Test 4: wrap of pc and of target sum
    drive(1'b1, 32'hFFFF_FFF0, 32'hC, 1'b0, 1'b0);
    tick(); tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t4_pc_top", ifu_req_pc, 32'hFFFF_FFFC);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("t4_pc_wrap", ifu_req_pc, 32'h0);
    tick();
    drive(1'b1, 32'hFFFF_FFF0, 32'h20, 1'b0, 1'b0);
    chk("t4_pulse", 32'(ifu_flush_pulse), 32'h1);
    tick();
    chk("t4_ack", 32'(brchmis_flush_ack), 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("t4_tgt_wrap", ifu_req_pc, 32'h10);
    tick();

    // Test 6: reset in DRAIN abandons the flush
    drive(1'b1, 32'h300, 32'h0, 1'b1, 1'b0);
    chk("t6_pulse", 32'(ifu_flush_pulse), 32'h1);
    tick();
    chk("t6_drain_ack", 32'(brchmis_flush_ack), 32'h0);
    rst = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    chk("t6_rst_ack", 32'(brchmis_flush_ack), 32'h0);
    chk("t6_rst_pc", ifu_req_pc, 32'h0);
    chk("t6_rst_valid", 32'(ifu_req_valid), 32'h0);
`ifdef QPU_IFU_FLUSH_CNT_EN
    chk("t6_cnt_rst", flush_cnt, 32'h0);
`endif
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    chk("t6_post_ack", 32'(brchmis_flush_ack), 32'h0);
    chk("t6_post_pc", ifu_req_pc, 32'h0);
    chk("t6_post_valid", 32'(ifu_req_valid), 32'h1);
`ifdef QPU_IFU_FLUSH_CNT_EN
    drive(1'b1, 32'h80, 32'h0, 1'b0, 1'b0);
    tick();
    chk("t6_cnt_ack", 32'(brchmis_flush_ack), 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("t6_cnt_one", flush_cnt, 32'h1);
    chk("t6_cnt_pc", ifu_req_pc, 32'h80);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
